// File: rtl/modbus_rx_frame_ctrl.sv
// modbus_rx_frame_ctrl
//   Frames Modbus RTU requests out of the UART byte stream using the t3.5 silence gap,
//   sequences an external 6-byte CRC engine over each 8-byte request, checks the
//   returned CRC against the received CRC and the slave address, and hands decoded
//   function/address/data to the register handler with a 1-cycle valid pulse.
//
// Ports
//   clk_in       system clock
//   rst_n_in     asynchronous reset, active low
//   rx_done      1-cycle pulse, rx_data holds a new byte
//   rx_data      received byte
//   dev_addr     this slave's address
//   crc_done     1-cycle pulse from CRC engine, crc_out valid
//   crc_out      CRC engine result (low byte in [7:0])
//   crc_start    1-cycle pulse to CRC engine
//   crc_data     CRC engine data, byte0 in [7:0] .. byte5 in [47:40]
//   frame_valid  1-cycle pulse, good request for this slave
//   frame_err    1-cycle pulse, bad frame (err_code valid same cycle)
//   err_code     0 none, 1 length, 2 CRC mismatch, 3 CRC timeout
//   rx_func      function code (byte1)
//   rx_reg_addr  {byte2, byte3}
//   rx_reg_data  {byte4, byte5}
//   busy         high whenever not idle
module modbus_rx_frame_ctrl #(
  parameter int unsigned T35_CYCLES  = 200520,
  parameter int unsigned CRC_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic [7:0]  dev_addr,
  input  logic        crc_done,
  input  logic [15:0] crc_out,
  output logic        crc_start,
  output logic [47:0] crc_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  rx_func,
  output logic [15:0] rx_reg_addr,
  output logic [15:0] rx_reg_data,
  output logic        busy
);

  localparam int unsigned TimerW = (T35_CYCLES > 2) ? $clog2(T35_CYCLES) : 1;
  localparam int unsigned WaitW  = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StRecv, StEval, StCrcReq, StCrcWait, StCheck} state_e;

  state_e              state_q, state_d;
  logic [63:0]         buf_q, buf_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [15:0]         crc_q, crc_d;
  logic [1:0]          err_q, err_d;
  logic [7:0]          func_q, func_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         data_q, data_d;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    wait_d      = wait_q;
    crc_d       = crc_q;
    err_d       = err_q;
    func_d      = func_q;
    addr_d      = addr_q;
    data_d      = data_q;
    crc_start   = 1'b0;
    frame_valid = 1'b0;
    frame_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_done) begin
          buf_d[7:0] = rx_data;
          cnt_d      = 4'd1;
          timer_d    = '0;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        // A byte on the expiry cycle wins and extends the frame.
        if (rx_done) begin
          if (cnt_q < 4'd8) begin
            buf_d[{cnt_q[2:0], 3'b000} +: 8] = rx_data;
          end
          cnt_d   = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
          timer_d = '0;
        end else if (timer_q == TimerW'(T35_CYCLES - 1)) begin
          state_d = StEval;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StEval: begin
        if (cnt_q != 4'd8) begin
          frame_err = 1'b1;
          err_d     = 2'd1;
          state_d   = StIdle;
        end else begin
          state_d = StCrcReq;
        end
      end
      StCrcReq: begin
        crc_start = 1'b1;
        wait_d    = '0;
        state_d   = StCrcWait;
      end
      StCrcWait: begin
        if (crc_done) begin
          crc_d   = crc_out;
          state_d = StCheck;
        end else if (wait_q == WaitW'(CRC_TIMEOUT)) begin
          frame_err = 1'b1;
          err_d     = 2'd3;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheck: begin
        // Received CRC is byte6 (low) then byte7 (high).
        if (crc_q != buf_q[63:48]) begin
          frame_err = 1'b1;
          err_d     = 2'd2;
        end else if ((buf_q[7:0] == dev_addr) || (buf_q[7:0] == 8'd0)) begin
          frame_valid = 1'b1;
          err_d       = 2'd0;
          func_d      = buf_q[15:8];
          addr_d      = {buf_q[23:16], buf_q[31:24]};
          data_d      = {buf_q[39:32], buf_q[47:40]};
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      wait_q  <= '0;
      crc_q   <= '0;
      err_q   <= '0;
      func_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Result registers are bypassed so new values appear with the pulse.
  assign err_code    = err_d;
  assign rx_func     = func_d;
  assign rx_reg_addr = addr_d;
  assign rx_reg_data = data_d;
  assign crc_data    = buf_q[47:0];
  assign busy        = (state_q != StIdle);

endmodule
